// File: rtl/pong_pkg.sv
// Shared definitions for the pong ball engine: FSM encoding, serve centre,
// speed ceiling and direction encodings.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_e;

  localparam logic [9:0] SERVE_X   = 10'd312;
  localparam logic [9:0] SERVE_Y   = 10'd232;
  localparam logic [3:0] MAX_SPEED = 4'd8;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

endpackage

// File: rtl/pong_collide.sv
// Combinational per-frame ball step: advances the ball by one frame and
// resolves wall bounces, paddle hits and misses on the new position.
module pong_collide
  import pong_pkg::*;
#(
  parameter int H_VIDEO       = 640,
  parameter int V_VIDEO       = 480,
  parameter int SQUARE_WIDTH  = 16,
  parameter int PADDLE_WIDTH  = 12,
  parameter int PADDLE_HEIGHT = 96,
  parameter int PADDLE1_X     = 32,
  parameter int PADDLE2_X     = 596
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       dx,
  input  logic       dy,
  input  logic [3:0] speed,
  input  logic [9:0] paddle1_ypos,
  input  logic [9:0] paddle2_ypos,
  output logic [9:0] x_nxt,
  output logic [9:0] y_nxt,
  output logic       dx_nxt,
  output logic       dy_nxt,
  output logic       miss_left,
  output logic       miss_right
);

  localparam logic signed [11:0] SQ       = 12'(SQUARE_WIDTH);
  localparam logic signed [11:0] PH       = 12'(PADDLE_HEIGHT);
  localparam logic signed [11:0] P1_LEFT  = 12'(PADDLE1_X);
  localparam logic signed [11:0] P1_RIGHT = 12'(PADDLE1_X + PADDLE_WIDTH);
  localparam logic signed [11:0] P2_LEFT  = 12'(PADDLE2_X);
  localparam logic signed [11:0] P2_RIGHT = 12'(PADDLE2_X + PADDLE_WIDTH);
  localparam logic signed [11:0] X_MAX    = 12'(H_VIDEO - 1 - SQUARE_WIDTH);
  localparam logic signed [11:0] Y_MAX    = 12'(V_VIDEO - 1 - SQUARE_WIDTH);

  logic signed [10:0] step;
  logic signed [10:0] nx;
  logic signed [10:0] ny;
  logic signed [11:0] nx_w;
  logic signed [11:0] ny_w;
  logic signed [11:0] y_w;
  logic signed [11:0] p1_w;
  logic signed [11:0] p2_w;
  logic               hit1;
  logic               hit2;

  always_comb begin
    step = $signed({7'd0, speed});
    nx   = (dx == DIR_LEFT) ? $signed({1'b0, x}) - step : $signed({1'b0, x}) + step;
    ny   = (dy == DIR_UP)   ? $signed({1'b0, y}) - step : $signed({1'b0, y}) + step;
    // Widen before adding extents so paddle-edge sums cannot wrap.
    nx_w = {nx[10], nx};
    ny_w = {ny[10], ny};
    y_w  = {2'b00, y};
    p1_w = {2'b00, paddle1_ypos};
    p2_w = {2'b00, paddle2_ypos};

    hit1 = (dx == DIR_LEFT) && (nx_w <= P1_RIGHT) && (nx_w + SQ >= P1_LEFT) &&
           (y_w + SQ >= p1_w) && (y_w <= p1_w + PH);
    hit2 = (dx == DIR_RIGHT) && (nx_w + SQ >= P2_LEFT) && (nx_w <= P2_RIGHT) &&
           (y_w + SQ >= p2_w) && (y_w <= p2_w + PH);
    miss_left  = (nx_w < 12'sd0);
    miss_right = (nx_w > X_MAX);

    y_nxt  = ny[9:0];
    dy_nxt = dy;
    if (ny_w < 12'sd0) begin
      y_nxt  = '0;
      dy_nxt = DIR_DOWN;
    end else if (ny_w > Y_MAX) begin
      y_nxt  = Y_MAX[9:0];
      dy_nxt = DIR_UP;
    end

    x_nxt  = nx[9:0];
    dx_nxt = dx;
    if (hit1) begin
      x_nxt  = 10'(PADDLE1_X + PADDLE_WIDTH + 1);
      dx_nxt = DIR_RIGHT;
    end else if (hit2) begin
      x_nxt  = 10'(PADDLE2_X - SQUARE_WIDTH - 1);
      dx_nxt = DIR_LEFT;
    end else if (miss_left) begin
      dx_nxt = DIR_LEFT;
    end else if (miss_right) begin
      dx_nxt = DIR_RIGHT;
    end
  end

endmodule

// File: rtl/pong_ball_engine.sv
// Pong ball FSM (IDLE/SERVE/PLAY/OVER) with scoring and serve timing.
// Define PONG_BALL_SPEEDUP_EN to make paddle hits speed the ball up.
module pong_ball_engine
  import pong_pkg::*;
#(
  parameter int H_VIDEO       = 640,
  parameter int V_VIDEO       = 480,
  parameter int SQUARE_WIDTH  = 16,
  parameter int PADDLE_WIDTH  = 12,
  parameter int PADDLE_HEIGHT = 96,
  parameter int PADDLE1_X     = 32,
  parameter int PADDLE2_X     = 596,
  parameter int WIN_SCORE     = 11,
  parameter int SERVE_DELAY   = 60,
  parameter int BALL_SPEED    = 4
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] paddle1_ypos,
  input  logic [9:0] paddle2_ypos,
  output logic [9:0] square_xpos,
  output logic [9:0] square_ypos,
  output logic       sq_shown,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       game_over,
  output logic       in_menu
);

  localparam int                CNT_W    = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SERVE_DELAY - 1);
  localparam logic [3:0]        WIN      = 4'(WIN_SCORE);

  state_e           state_q, state_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic             dx_q, dx_d, dy_q, dy_d;
  logic             serve_dy_q, serve_dy_d;
  logic             shown_q, shown_d;
  logic [3:0]       score1_q, score1_d, score2_q, score2_d;
  logic             over_q, over_d;
  logic             menu_q, menu_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       speed;
  logic             win;

  logic [9:0] c_x, c_y;
  logic       c_dx, c_dy, c_miss_left, c_miss_right;

`ifdef PONG_BALL_SPEEDUP_EN
  logic [3:0] speed_q, speed_d;
  assign speed = speed_q;
`else
  assign speed = 4'(BALL_SPEED);
`endif

  pong_collide #(
    .H_VIDEO      (H_VIDEO),
    .V_VIDEO      (V_VIDEO),
    .SQUARE_WIDTH (SQUARE_WIDTH),
    .PADDLE_WIDTH (PADDLE_WIDTH),
    .PADDLE_HEIGHT(PADDLE_HEIGHT),
    .PADDLE1_X    (PADDLE1_X),
    .PADDLE2_X    (PADDLE2_X)
  ) u_collide (
    .x           (x_q),
    .y           (y_q),
    .dx          (dx_q),
    .dy          (dy_q),
    .speed       (speed),
    .paddle1_ypos(paddle1_ypos),
    .paddle2_ypos(paddle2_ypos),
    .x_nxt       (c_x),
    .y_nxt       (c_y),
    .dx_nxt      (c_dx),
    .dy_nxt      (c_dy),
    .miss_left   (c_miss_left),
    .miss_right  (c_miss_right)
  );

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    serve_dy_d = serve_dy_q;
    shown_d    = shown_q;
    score1_d   = score1_q;
    score2_d   = score2_q;
    over_d     = over_q;
    cnt_d      = cnt_q;
    win        = 1'b0;
`ifdef PONG_BALL_SPEEDUP_EN
    speed_d    = speed_q;
`endif

    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d  = SERVE;
          score1_d = '0;
          score2_d = '0;
          dx_d     = DIR_RIGHT;
          over_d   = 1'b0;
          cnt_d    = '0;
          x_d      = SERVE_X;
          y_d      = SERVE_Y;
          shown_d  = 1'b0;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d    = PLAY;
            shown_d    = 1'b1;
            cnt_d      = '0;
            dy_d       = serve_dy_q;
            serve_dy_d = ~serve_dy_q;
`ifdef PONG_BALL_SPEEDUP_EN
            speed_d    = 4'(BALL_SPEED);
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PLAY: begin
        if (frame_tick) begin
          x_d  = c_x;
          y_d  = c_y;
          dx_d = c_dx;
          dy_d = c_dy;
`ifdef PONG_BALL_SPEEDUP_EN
          // dx only flips on a paddle hit; walls and misses leave it alone.
          if ((c_dx != dx_q) && (speed_q < MAX_SPEED)) speed_d = speed_q + 4'd1;
`endif
          if (c_miss_left || c_miss_right) begin
            shown_d = 1'b0;
            x_d     = SERVE_X;
            y_d     = SERVE_Y;
            cnt_d   = '0;
            if (c_miss_left) begin
              score2_d = score2_q + 4'd1;
              win      = (score2_q + 4'd1 == WIN);
            end else begin
              score1_d = score1_q + 4'd1;
              win      = (score1_q + 4'd1 == WIN);
            end
            state_d = win ? OVER : SERVE;
            over_d  = win;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    menu_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_0) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= SERVE_X;
      y_q        <= SERVE_Y;
      dx_q       <= DIR_RIGHT;
      dy_q       <= DIR_DOWN;
      serve_dy_q <= DIR_DOWN;
      shown_q    <= 1'b0;
      score1_q   <= '0;
      score2_q   <= '0;
      over_q     <= 1'b0;
      menu_q     <= 1'b1;
      cnt_q      <= '0;
`ifdef PONG_BALL_SPEEDUP_EN
      speed_q    <= 4'(BALL_SPEED);
`endif
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      serve_dy_q <= serve_dy_d;
      shown_q    <= shown_d;
      score1_q   <= score1_d;
      score2_q   <= score2_d;
      over_q     <= over_d;
      menu_q     <= menu_d;
      cnt_q      <= cnt_d;
`ifdef PONG_BALL_SPEEDUP_EN
      speed_q    <= speed_d;
`endif
    end
  end

  assign square_xpos = x_q;
  assign square_ypos = y_q;
  assign sq_shown    = shown_q;
  assign score_p1    = score1_q;
  assign score_p2    = score2_q;
  assign game_over   = over_q;
  assign in_menu     = menu_q;

endmodule

// File: doc/pong_ball_engine.md
PONG_BALL_ENGINE -- requirements
Module: pong_ball_engine

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- H_VIDEO, 640, active width in pixels
- V_VIDEO, 480, active height in lines
- SQUARE_WIDTH, 16, ball extent; ball occupies [pos, pos+SQUARE_WIDTH] on each axis
- PADDLE_WIDTH, 12, paddle thickness
- PADDLE_HEIGHT, 96, paddle height
- PADDLE1_X, 32, left edge of paddle1
- PADDLE2_X, 596, left edge of paddle2
- WIN_SCORE, 11, winning score; legal range 1..15
- SERVE_DELAY, 60, frames the ball stays hidden before each serve
- BALL_SPEED, 4, pixels per frame on each axis
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk_0, in, 1, 25.175 MHz pixel clock; the only clock
- rst, in, 1, synchronous active-high reset
- frame_tick, in, 1, one-cycle pulse once per frame, issued after the last active line
- start, in, 1, one-cycle "any key" pulse
- paddle1_ypos, in, 10, top of paddle1
- paddle2_ypos, in, 10, top of paddle2
- square_xpos, out, 10, top-left x of the ball
- square_ypos, out, 10, top-left y of the ball
- sq_shown, out, 1, ball visible
- score_p1, out, 4, player 1 score
- score_p2, out, 4, player 2 score
- game_over, out, 1, a player has reached WIN_SCORE
- in_menu, out, 1, high in IDLE (drives startup text)

Function
REQ-003 The FSM SHALL have four states: IDLE, SERVE, PLAY and OVER; all outputs are registered.
REQ-004 A start pulse in IDLE or OVER SHALL clear both scores, set dx to right, and enter SERVE on the next edge; start SHALL be ignored in SERVE and PLAY.
REQ-005 In SERVE: ball at (312, 232), sq_shown=0, the frame counter counts frame_tick pulses, and after SERVE_DELAY ticks the FSM SHALL enter PLAY with sq_shown=1.
REQ-006 Each serve SHALL toggle the dy sign, starting with down after reset.
REQ-007 In PLAY, each frame_tick SHALL move the ball by ±speed per axis, using 11-bit signed intermediates; the new position SHALL be visible on the cycle after the tick.
REQ-008 Top wall: if next y < 0, y SHALL be clamped to 0 and dy set to down.
REQ-009 Bottom wall: if next y > V_VIDEO-1-SQUARE_WIDTH, y SHALL be clamped to that value and dy set to up.
REQ-010 Paddle1 hit SHALL be detected when all of the following hold:
- dx is left
- next x ≤ PADDLE1_X+PADDLE_WIDTH
- next x+SQUARE_WIDTH ≥ PADDLE1_X
- y+SQUARE_WIDTH ≥ paddle1_ypos
- y ≤ paddle1_ypos+PADDLE_HEIGHT

On a hit, x SHALL be set to PADDLE1_X+PADDLE_WIDTH+1 and dx to right.
REQ-011 Paddle2 hit SHALL be the mirror of REQ-010: x SHALL be set to PADDLE2_X-SQUARE_WIDTH-1 and dx to left.
REQ-012 A wall bounce and a paddle hit in the same frame SHALL both be applied.
REQ-013 Miss left (next x < 0) SHALL increment score_p2; miss right (next x > H_VIDEO-1-SQUARE_WIDTH) SHALL increment score_p1; either SHALL set sq_shown=0.
REQ-014 After a miss, dx SHALL point toward the conceding player.
REQ-015 After a miss, if the incremented score equals WIN_SCORE the FSM SHALL enter OVER with game_over=1; otherwise it SHALL enter SERVE.
REQ-016 In OVER the ball SHALL stay hidden and the scores SHALL be held.
REQ-017 frame_tick SHALL be ignored in IDLE and OVER; when start and frame_tick coincide, start wins and the tick is dropped.

Reset
REQ-018 rst SHALL override all inputs and, on the next edge, set state=IDLE, ball=(312,232), sq_shown=0, scores=0, game_over=0, in_menu=1, frame counter=0, dy=down, dx=right and speed=BALL_SPEED, including when asserted mid-PLAY.

Configuration
REQ-019 With macro PONG_BALL_SPEEDUP_EN defined, each paddle hit SHALL increment speed by 1 up to 8, and each serve SHALL restore speed to BALL_SPEED.
REQ-020 Without PONG_BALL_SPEEDUP_EN, speed SHALL be the constant BALL_SPEED and no speed register SHALL be built.

Structure
REQ-021 The shared package pong_pkg SHALL hold:
- the FSM state encoding
- the serve-centre constants 312/232
- the maximum speed 8
- the direction encodings
REQ-022 Collision detection (REQ-008..REQ-013) SHALL be a combinational sub-module, pong_collide, instanced once; the FSM and registers SHALL stay in pong_ball_engine.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Reset, then start, then 60 ticks → sq_shown rises on the cycle after the 60th tick, ball at (312,232).
- Ball at y=2, dy up, speed 4 → y=0 after the tick, dy down.
- paddle1_ypos=200, ball at (46,220) moving left → x=45, dx right, scores unchanged.
- Paddle1 away (ypos=0), ball at x=2 moving left → score_p2 +1, SERVE, sq_shown=0, dx left.
- score_p1=10, right miss → score_p1=11, game_over=1, OVER; then start → scores 0, game_over=0, SERVE.
- rst mid-PLAY at (100,100) → reset values on the next edge; a coincident start is ignored.
